// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite renderer.
// FSM states, default key codes, screen limits, address-width helper.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ROW,
    DRAW,
    LINE_END
  } state_t;

  localparam logic [7:0] KC_LEFT  = 8'h04;
  localparam logic [7:0] KC_RIGHT = 8'h07;
  localparam logic [7:0] KC_UP    = 8'h1A;
  localparam logic [7:0] KC_DOWN  = 8'h16;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// sprite_renderer_if: sprite ROM read port.
// master drives the address, slave returns data one Clk later.
interface sprite_renderer_if #(
  parameter int AW = 11,
  parameter int DW = 24
) ();
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_pos_ctrl.sv
// sprite_pos_ctrl: clamped per-frame keyboard motion.
// The new position is latched for rendering on frame_start.
module sprite_pos_ctrl
  import sprite_pkg::*;
#(
  parameter int WIDTH  = 36,
  parameter int HEIGHT = 40,
  parameter int SCALE  = 1,
  parameter int STEP   = 1,
  parameter int X_MIN  = 1,
  parameter int X_MAX  = SCREEN_W - 1,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = SCREEN_H - 1,
  parameter int MOVE_Y = 0,
  parameter logic [7:0] KEY_L = KC_LEFT,
  parameter logic [7:0] KEY_R = KC_RIGHT,
  parameter logic [7:0] KEY_U = KC_UP,
  parameter logic [7:0] KEY_D = KC_DOWN
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       enable,
  input  logic [7:0] keycode,
  input  logic [9:0] init_x,
  input  logic [9:0] init_y,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y
);

  localparam logic [10:0] XL = 11'(X_MIN);
  localparam logic [10:0] XR = 11'(X_MAX + 1 - WIDTH * SCALE);
  localparam logic [10:0] YT = 11'(Y_MIN);
  localparam logic [10:0] YB = 11'(Y_MAX + 1 - HEIGHT * SCALE);
  localparam logic [10:0] ST = 11'(STEP);

  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic [9:0]  spr_x_q, spr_y_q;
  logic [10:0] dec_x, inc_x, dec_y, inc_y;
  logic        key_l, key_r, key_u, key_d;

  assign key_l = (keycode == KEY_L);
  assign key_r = (keycode == KEY_R);
  assign key_u = (MOVE_Y != 0) && (keycode == KEY_U);
  assign key_d = (MOVE_Y != 0) && (keycode == KEY_D);

  // next position: 11-bit step, bit 10 flags a wrap below zero
  always_comb begin
    dec_x   = {1'b0, pos_x_q} - ST;
    inc_x   = {1'b0, pos_x_q} + ST;
    dec_y   = {1'b0, pos_y_q} - ST;
    inc_y   = {1'b0, pos_y_q} + ST;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    unique case (1'b1)
      key_l: pos_x_d = (dec_x[10] || dec_x < XL) ? XL[9:0] : dec_x[9:0];
      key_r: pos_x_d = (inc_x > XR) ? XR[9:0] : inc_x[9:0];
      key_u: pos_y_d = (dec_y[10] || dec_y < YT) ? YT[9:0] : dec_y[9:0];
      key_d: pos_y_d = (inc_y > YB) ? YB[9:0] : inc_y[9:0];
      default: ;
    endcase
  end

  // move and latch once per frame
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_q <= init_x;
      pos_y_q <= init_y;
      spr_x_q <= init_x;
      spr_y_q <= init_y;
    end else if (frame_start && enable) begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      spr_x_q <= pos_x_d;
      spr_y_q <= pos_y_d;
    end
  end

  assign sprite_x = spr_x_q;
  assign sprite_y = spr_y_q;

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: raster-aligned sprite pixel streamer with ROM prefetch.
// Optional colour-key transparency: define SPRITE_COLORKEY_EN.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int WIDTH   = 36,
  parameter int HEIGHT  = 40,
  parameter int SCALE   = 1,
  parameter int COLOR_W = 24,
  parameter int STEP    = 1,
  parameter int X_MIN   = 1,
  parameter int X_MAX   = SCREEN_W - 1,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = SCREEN_H - 1,
  parameter int MOVE_Y  = 0,
  parameter logic [7:0] KEY_L = KC_LEFT,
  parameter logic [7:0] KEY_R = KC_RIGHT,
  parameter logic [7:0] KEY_U = KC_UP,
  parameter logic [7:0] KEY_D = KC_DOWN
`ifdef SPRITE_COLORKEY_EN
  , parameter logic [COLOR_W-1:0] KEY_COLOR = '0
`endif
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               enable,
  input  logic [7:0]         keycode,
  input  logic [9:0]         init_x,
  input  logic [9:0]         init_y,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  sprite_renderer_if.master  rom,
  output logic               sprite_on,
  output logic [COLOR_W-1:0] sprite_color,
  output logic [9:0]         sprite_x,
  output logic [9:0]         sprite_y,
  output logic               busy
);

  localparam int AW = addr_w(WIDTH * HEIGHT);
  localparam int CW = addr_w(WIDTH);
  localparam int RW = addr_w(HEIGHT);
  localparam int SH = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam logic [1:0]    SL = 2'(SCALE - 1);
  localparam logic [CW-1:0] CL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RL = RW'(HEIGHT - 1);

  state_t               state_q;
  logic [RW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic [1:0]           sub_x_q, sub_y_q;
  logic [AW-1:0]        rom_addr_q, rom_addr_d;
  logic                 sprite_on_q, busy_q;
  logic [COLOR_W-1:0]   sprite_color_q;
  logic [10:0]          tgt_x, tgt_y;
  logic [AW-1:0]        row_base;
  logic                 hit, last_px, last_line, pix_on;

  sprite_pos_ctrl #(
    .WIDTH (WIDTH),  .HEIGHT(HEIGHT), .SCALE(SCALE), .STEP(STEP),
    .X_MIN (X_MIN),  .X_MAX (X_MAX),  .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .MOVE_Y(MOVE_Y), .KEY_L (KEY_L),  .KEY_R(KEY_R),
    .KEY_U (KEY_U),  .KEY_D (KEY_D)
  ) u_pos (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .enable     (enable),
    .keycode    (keycode),
    .init_x     (init_x),
    .init_y     (init_y),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y)
  );

  assign tgt_x     = {1'b0, sprite_x} - 11'd1;
  assign tgt_y     = {1'b0, sprite_y} + (11'(row_q) << SH) + 11'(sub_y_q);
  assign hit       = ({1'b0, DrawX} == tgt_x) && ({1'b0, DrawY} == tgt_y);
  assign row_base  = AW'(32'(row_q) * WIDTH);
  assign last_px   = (col_q == CL) && (sub_x_q == SL);
  assign last_line = (row_q == RL) && (sub_y_q == SL);

`ifdef SPRITE_COLORKEY_EN
  assign pix_on = (rom.rom_data != KEY_COLOR);
`else
  assign pix_on = 1'b1;
`endif

  // the ROM registers its address, so it is fed the next-state address:
  // data for a pixel is then on rom_data during that pixel's DRAW cycle
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (frame_start) begin
      rom_addr_d = '0;
    end else begin
      unique case (state_q)
        IDLE:     rom_addr_d = '0;
        WAIT_ROW: if (enable && hit) rom_addr_d = row_base;
        DRAW:     if (sub_x_q == SL) rom_addr_d = rom_addr_q + AW'(1);
        default:  ;
      endcase
    end
  end

  // raster FSM, counters and registered pixel outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      sub_x_q        <= '0;
      sub_y_q        <= '0;
      rom_addr_q     <= '0;
      sprite_on_q    <= 1'b0;
      sprite_color_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      if (frame_start) begin
        row_q          <= '0;
        col_q          <= '0;
        sub_x_q        <= '0;
        sub_y_q        <= '0;
        sprite_on_q    <= 1'b0;
        sprite_color_q <= '0;
        state_q        <= enable ? WAIT_ROW : IDLE;
        busy_q         <= enable;
      end else begin
        unique case (state_q)
          IDLE: begin
            row_q          <= '0;
            col_q          <= '0;
            sub_x_q        <= '0;
            sub_y_q        <= '0;
            sprite_on_q    <= 1'b0;
            sprite_color_q <= '0;
            busy_q         <= 1'b0;
          end
          WAIT_ROW: begin
            sprite_on_q    <= 1'b0;
            sprite_color_q <= '0;
            if (!enable) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (hit) begin
              state_q <= DRAW;
            end
          end
          DRAW: begin
            sprite_color_q <= rom.rom_data;
            sprite_on_q    <= pix_on;
            if (last_px) begin
              col_q   <= '0;
              sub_x_q <= '0;
              state_q <= LINE_END;
            end else if (sub_x_q == SL) begin
              sub_x_q <= '0;
              col_q   <= col_q + CW'(1);
            end else begin
              sub_x_q <= sub_x_q + 2'd1;
            end
          end
          LINE_END: begin
            sprite_on_q    <= 1'b0;
            sprite_color_q <= '0;
            col_q          <= '0;
            sub_x_q        <= '0;
            if (sub_y_q == SL) begin
              sub_y_q <= '0;
              row_q   <= row_q + RW'(1);
            end else begin
              sub_y_q <= sub_y_q + 2'd1;
            end
            if (last_line || !enable) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT_ROW;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom.rom_addr = rom_addr_d;
  assign sprite_on    = sprite_on_q;
  assign sprite_color = sprite_color_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed bench with scoreboard queues.
// Instance A: SCALE 1 with vertical motion; instance B: SCALE 2 raster.
module tb_sprite_renderer;
  import sprite_pkg::*;

  localparam int AW = addr_w(36 * 40);

  typedef struct {
    logic        on;
    logic [23:0] col;
  } pix_t;

  typedef struct {
    int x;
    int y;
  } pos_t;

  logic        Clk = 1'b0;
  logic        Reset_n, frame_start, enable;
  logic [7:0]  keycode_a, keycode_b;
  logic [9:0]  DrawX, DrawY;
  logic        on_a, on_b, busy_a, busy_b;
  logic [23:0] col_a, col_b;
  logic [9:0]  sx_a, sy_a, sx_b, sy_b;

  int checks   = 0;
  int failures = 0;
  int ma_x, ma_y, mb_x, mb_y;
  logic armed;
  pix_t pix_q[$];
  pos_t pos_q[$];

  sprite_renderer_if #(.AW(AW), .DW(24)) rom_a ();
  sprite_renderer_if #(.AW(AW), .DW(24)) rom_b ();

  sprite_renderer #(.SCALE(1), .MOVE_Y(1)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .enable(enable), .keycode(keycode_a),
    .init_x(10'd100), .init_y(10'd400),
    .DrawX(DrawX), .DrawY(DrawY), .rom(rom_a),
    .sprite_on(on_a), .sprite_color(col_a),
    .sprite_x(sx_a), .sprite_y(sy_a), .busy(busy_a)
  );

  sprite_renderer #(.SCALE(2), .MOVE_Y(0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .enable(enable), .keycode(keycode_b),
    .init_x(10'd10), .init_y(10'd20),
    .DrawX(DrawX), .DrawY(DrawY), .rom(rom_b),
    .sprite_on(on_b), .sprite_color(col_b),
    .sprite_x(sx_b), .sprite_y(sy_b), .busy(busy_b)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_word(input logic [AW-1:0] a);
`ifdef SPRITE_COLORKEY_EN
    return (a == AW'(5)) ? 24'h0 : (24'(a) | 24'h100000);
`else
    return 24'(a);
`endif
  endfunction

  always @(posedge Clk) rom_a.rom_data <= rom_word(rom_a.rom_addr);
  always @(posedge Clk) rom_b.rom_data <= rom_word(rom_b.rom_addr);

  function automatic int step(input int p, input int lo, input int hi,
                              input logic [7:0] k, input logic [7:0] kdec,
                              input logic [7:0] kinc);
    if (k == kdec) return (p - 1 < lo) ? lo : p - 1;
    if (k == kinc) return (p + 1 > hi) ? hi : p + 1;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic frame_pulse();
    pos_t e, g;
    @(negedge Clk);
    frame_start = 1'b1;
    if (enable) begin
      ma_x = step(ma_x, 1, 604, keycode_a, 8'h04, 8'h07);
      ma_y = step(ma_y, 0, 440, keycode_a, 8'h1A, 8'h16);
      mb_x = step(mb_x, 1, 568, keycode_b, 8'h04, 8'h07);
    end
    armed = enable;
    e.x = ma_x;
    e.y = ma_y;
    pos_q.push_back(e);
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    g = pos_q.pop_front();
    chk("sprite_x_a", 32'(sx_a), 32'(g.x));
    chk("sprite_y_a", 32'(sy_a), 32'(g.y));
  endtask

  task automatic pixel(input int x, input int y, input logic fs);
    pix_t e, g;
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    frame_start = fs;
    e.on  = 1'b0;
    e.col = '0;
    if (fs) begin
      if (enable) mb_x = step(mb_x, 1, 568, keycode_b, 8'h04, 8'h07);
      armed = enable;
    end else if (armed && x >= mb_x && x < mb_x + 72 &&
                 y >= mb_y && y < mb_y + 80) begin
      e.col = rom_word(AW'(((y - mb_y) / 2) * 36 + (x - mb_x) / 2));
      e.on  = 1'b1;
`ifdef SPRITE_COLORKEY_EN
      e.on  = (e.col != 24'h0);
`endif
    end
    pix_q.push_back(e);
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    g = pix_q.pop_front();
    chk("sprite_on_b", 32'(on_b), 32'(g.on));
    chk("sprite_color_b", 32'(col_b), 32'(g.col));
  endtask

  task automatic scan_frame(input int stop_x, input int stop_y);
    for (int y = 0; y < 104; y++) begin
      for (int x = 0; x < 90; x++) begin
        if (y == stop_y && x == stop_x) begin
          pixel(x, y, 1'b1);
          return;
        end
        pixel(x, y, 1'b0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n     = 1'b1;
    frame_start = 1'b0;
    enable      = 1'b1;
    keycode_a   = 8'h00;
    keycode_b   = 8'h00;
    DrawX       = '0;
    DrawY       = '0;
    ma_x = 100; ma_y = 400;
    mb_x = 10;  mb_y = 20;
    armed = 1'b0;

    #1 Reset_n = 1'b0;
    #1;
    chk("rst_sprite_x_a", 32'(sx_a), 32'd100);
    chk("rst_sprite_y_a", 32'(sy_a), 32'd400);
    chk("rst_sprite_on_a", 32'(on_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_color_a", 32'(col_a), 32'd0);
    chk("rst_rom_addr_a", 32'(rom_a.rom_addr), 32'd0);
    chk("rst_sprite_x_b", 32'(sx_b), 32'd10);
    chk("rst_sprite_y_b", 32'(sy_b), 32'd20);

    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    keycode_a = 8'h04;
    repeat (150) frame_pulse();
    chk("left_clamp", 32'(sx_a), 32'd1);

    keycode_a = 8'h07;
    repeat (620) frame_pulse();
    chk("right_clamp", 32'(sx_a), 32'd604);

    keycode_a = 8'h16;
    repeat (50) frame_pulse();
    chk("down_clamp", 32'(sy_a), 32'd440);

    keycode_a = 8'h1A;
    repeat (3) frame_pulse();

    keycode_a = 8'h2C;
    repeat (2) frame_pulse();

    enable    = 1'b0;
    keycode_a = 8'h04;
    frame_pulse();
    chk("disabled_busy_a", 32'(busy_a), 32'd0);
    enable    = 1'b1;
    keycode_a = 8'h00;

    pixel(0, 0, 1'b1);
    chk("frame_busy_b", 32'(busy_b), 32'd1);
    scan_frame(-1, -1);
    chk("end_busy_b", 32'(busy_b), 32'd0);

    pixel(0, 0, 1'b1);
    keycode_b = 8'h07;
    scan_frame(40, 30);
    keycode_b = 8'h00;
    chk("abort_busy_b", 32'(busy_b), 32'd1);
    chk("abort_sprite_x_b", 32'(sx_b), 32'd11);
    chk("abort_sprite_y_b", 32'(sy_b), 32'd20);

    scan_frame(-1, -1);
    chk("restart_end_busy_b", 32'(busy_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
